// File: rtl/cpu_boot_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_boot_mem_pkg
// Description : Shared widths and boot-loader state encoding for the CPU
//               boot memory and for CPU-level integration.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_boot_mem_pkg;

  // Memory geometry; must agree with the CPU address and data ports
  localparam int BOOT_AW    = 4;
  localparam int BOOT_DW    = 8;
  localparam int BOOT_DEPTH = 16;

  // Default number of cycles the CPU stays in clear after the last byte
  localparam int BOOT_HOLD_CYCLES = 2;

  // Width of the hold counter; covers hold lengths 1..7
  localparam int BOOT_HCW = 3;

  // Boot-loader state encoding
  typedef logic [1:0] bootState_t;

  localparam bootState_t c_stateLoad = 2'd0;  // accepting loader bytes
  localparam bootState_t c_stateHold = 2'd1;  // load done, CPU still held
  localparam bootState_t c_stateRun  = 2'd2;  // CPU released

endpackage : cpu_boot_mem_pkg
`default_nettype wire

// File: rtl/cpu_boot_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : boot_mem_array
// Description : DEPTH x DW register array with one synchronous write port,
//               one combinational read port and asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_mem_array #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Storage: whole array clears on reset, single write port otherwise
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read is purely combinational, so a same-cycle write shows the old word
  assign rdata = r_mem[raddr];

endmodule : boot_mem_array
`default_nettype wire

// File: rtl/cpu_boot_mem.sv
`default_nettype none
// ============================================================================
// Module      : cpu_boot_mem
// Description : CPU program/data memory with a built-in boot loader. After
//               reset (or a reload pulse) the CPU is held in clear while a
//               byte stream is written from address 0 upward; a short hold
//               then lets the CPU's synchronous clears settle before release.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_boot_mem
  import cpu_boot_mem_pkg::*;
#(
  parameter int AW          = BOOT_AW,
  parameter int DW          = BOOT_DW,
  parameter int DEPTH       = BOOT_DEPTH,
  parameter int HOLD_CYCLES = BOOT_HOLD_CYCLES
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          reload,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          cpu_clr,
  input  logic          read,
  input  logic          write,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] memoryIn,
  output logic [DW-1:0] memoryOut,
  output logic [AW:0]   load_count,
  output logic          running
);

  // Last writable pointer value and the saturation value of the byte count
  localparam logic [AW-1:0]       c_ptrMax   = AW'(DEPTH - 1);
  localparam logic [AW:0]         c_countMax = (AW + 1)'(DEPTH);
  // Counter value on which the hold phase ends
  localparam logic [BOOT_HCW-1:0] c_holdLast = BOOT_HCW'(HOLD_CYCLES - 1);

  bootState_t          r_state;
  logic [AW-1:0]       r_ptr;
  logic [AW:0]         r_loadCount;
  logic [BOOT_HCW-1:0] r_holdCnt;

  logic          w_inLoad;
  logic          w_inHold;
  logic          w_inRun;
  logic          w_loadFire;
  logic          w_cpuFire;
  logic          w_lastByte;
  logic          w_holdDone;
  logic          w_memWe;
  logic [AW-1:0] w_memWaddr;
  logic [DW-1:0] w_memWdata;
  logic          w_unusedRead;

  // ---------------------------------------------------------------------------
  // State decode
  // ---------------------------------------------------------------------------
  assign w_inLoad = (r_state == c_stateLoad);
  assign w_inHold = (r_state == c_stateHold);
  assign w_inRun  = (r_state == c_stateRun);

  // A reload pulse drops any loader byte or CPU write offered in the same cycle
  assign w_loadFire = w_inLoad && load_valid && !reload;
  assign w_cpuFire  = w_inRun  && write      && !reload;

  // The 16th byte ends the load even without load_last, so ptr never wraps
  assign w_lastByte = load_last || (r_ptr == c_ptrMax);
  assign w_holdDone = (r_holdCnt == c_holdLast);

  // read only qualifies the bus for the CPU; it has no effect inside the block
  assign w_unusedRead = read;

  // ---------------------------------------------------------------------------
  // Loader / CPU control FSM, write pointer, byte count and hold counter
  // ---------------------------------------------------------------------------
  // Sequences LOAD -> HOLD -> RUN; reload re-enters LOAD from any state
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= c_stateLoad;
      r_ptr       <= '0;
      r_loadCount <= '0;
      r_holdCnt   <= '0;
    end else if (reload) begin
      r_state     <= c_stateLoad;
      r_ptr       <= '0;
      r_loadCount <= '0;
      r_holdCnt   <= '0;
    end else begin
      case (r_state)
        c_stateLoad: begin
          if (load_valid) begin
            if (r_loadCount != c_countMax) begin
              r_loadCount <= r_loadCount + 1'b1;
            end
            if (w_lastByte) begin
              r_state   <= c_stateHold;
              r_holdCnt <= '0;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        c_stateHold: begin
          if (w_holdDone) begin
            r_state   <= c_stateRun;
            r_holdCnt <= '0;
          end else begin
            r_holdCnt <= r_holdCnt + 1'b1;
          end
        end
        c_stateRun: begin
          r_state <= c_stateRun;
        end
        default: begin
          r_state     <= c_stateLoad;
          r_ptr       <= '0;
          r_loadCount <= '0;
          r_holdCnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Single write port, owned by the loader in LOAD and by the CPU in RUN
  // ---------------------------------------------------------------------------
  assign w_memWe    = w_loadFire || w_cpuFire;
  assign w_memWaddr = w_inLoad ? r_ptr     : address;
  assign w_memWdata = w_inLoad ? load_data : memoryIn;

  boot_mem_array #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_memArray (
    .clk   (clk),
    .clr_n (clr_n),
    .we    (w_memWe),
    .waddr (w_memWaddr),
    .wdata (w_memWdata),
    .raddr (address),
    .rdata (memoryOut)
  );

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from registered state
  // ---------------------------------------------------------------------------
  assign load_ready = w_inLoad;
  assign cpu_clr    = w_inLoad || w_inHold;
  assign running    = w_inRun;
  assign load_count = r_loadCount;

endmodule : cpu_boot_mem
`default_nettype wire

// File: tb/tb_cpu_boot_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_boot_mem
// Description : Self-checking bench for cpu_boot_mem: directed boot-loader
//               scenarios followed by randomized traffic, all checked against
//               a behavioural model of the loader and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_mem;

  localparam int AW          = 4;
  localparam int DW          = 8;
  localparam int DEPTH       = 16;
  localparam int HOLD_CYCLES = 2;

  logic          clk;
  logic          clr_n;
  logic          reload;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          cpu_clr;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] memoryIn;
  logic [DW-1:0] memoryOut;
  logic [AW:0]   load_count;
  logic          running;

  cpu_boot_mem #(
    .AW          (AW),
    .DW          (DW),
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .reload     (reload),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_clr    (cpu_clr),
    .read       (read),
    .write      (write),
    .address    (address),
    .memoryIn   (memoryIn),
    .memoryOut  (memoryOut),
    .load_count (load_count),
    .running    (running)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks;
  int nFails;

  // Behavioural model: memory image, bytes in current load, loading flag and
  // remaining held cycles after a load completes
  logic [DW-1:0] mMem [DEPTH];
  int            mCount;
  bit            mLoading;
  int            mHoldLeft;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
    mCount    = 0;
    mLoading  = 1'b1;
    mHoldLeft = 0;
  endtask

  // Apply one clock edge's worth of rules using the inputs present at the edge
  task automatic modelEdge();
    if (reload) begin
      mLoading  = 1'b1;
      mCount    = 0;
      mHoldLeft = 0;
    end else if (mLoading) begin
      if (load_valid) begin
        mMem[mCount] = load_data;
        mCount++;
        if (load_last || mCount == DEPTH) begin
          mLoading  = 1'b0;
          mHoldLeft = HOLD_CYCLES;
        end
      end
    end else if (mHoldLeft > 0) begin
      mHoldLeft--;
    end else if (write) begin
      mMem[address] = memoryIn;
    end
  endtask

  task automatic checkOutputs();
    bit held;
    held = mLoading || (mHoldLeft > 0);
    checkVal("cpu_clr",    32'(cpu_clr),    32'(held));
    checkVal("load_ready", 32'(load_ready), 32'(mLoading));
    checkVal("running",    32'(running),    32'(!held));
    checkVal("load_count", 32'(load_count), 32'(mCount));
    checkVal("memoryOut",  32'(memoryOut),  32'(mMem[address]));
  endtask

  // One cycle: check outputs mid-cycle, then advance DUT and model together
  task automatic tick();
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idleInputs();
    reload     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    write      = 1'b0;
    memoryIn   = '0;
  endtask

  task automatic sendByte(input logic [DW-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic sweepMemory();
    write = 1'b0;
    read  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      address = AW'(i);
      tick();
    end
    read = 1'b0;
  endtask

  // Asynchronous reset in mid-cycle: outputs must respond without a clock
  task automatic asyncReset();
    idleInputs();
    #2;
    clr_n = 1'b0;
    modelReset();
    #1;
    checkVal("rst_cpu_clr",    32'(cpu_clr),    32'd1);
    checkVal("rst_load_ready", 32'(load_ready), 32'd1);
    checkVal("rst_running",    32'(running),    32'd0);
    checkVal("rst_load_count", 32'(load_count), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      address = AW'(i);
      #1;
      checkVal("rst_memoryOut", 32'(memoryOut), 32'(mMem[i]));
    end
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  initial begin
    int holdLen;
    nChecks = 0;
    nFails  = 0;
    clr_n   = 1'b0;
    read    = 1'b0;
    address = '0;
    idleInputs();
    modelReset();

    // Power-on reset
    asyncReset();
    tick();

    // Three-byte load with stalls between the first and second bytes
    sendByte(8'h41, 1'b0);
    tick();
    tick();
    sendByte(8'h52, 1'b0);
    // Last byte, then spurious CPU writes while the CPU is still held
    load_valid = 1'b1;
    load_data  = 8'h63;
    load_last  = 1'b1;
    tick();
    idleInputs();
    write    = 1'b1;
    address  = 4'h0;
    memoryIn = 8'hEE;
    holdLen  = 0;
    while (cpu_clr && holdLen < 10) begin
      tick();
      holdLen++;
    end
    write = 1'b0;
    checkVal("hold_len", 32'(holdLen), 32'(HOLD_CYCLES));
    checkVal("count3",   32'(load_count), 32'd3);
    sweepMemory();

    // CPU write in RUN: old word this cycle, new word next cycle
    address  = 4'hA;
    memoryIn = 8'h5C;
    write    = 1'b1;
    tick();
    write = 1'b0;
    tick();
    checkVal("run_write", 32'(memoryOut), 32'h5C);

    // Reload together with a CPU write: write must be dropped
    address  = 4'h3;
    memoryIn = 8'h99;
    write    = 1'b1;
    reload   = 1'b1;
    tick();
    idleInputs();
    checkVal("reload_clr", 32'(cpu_clr), 32'd1);
    sendByte(8'hFF, 1'b1);
    for (int i = 0; i < HOLD_CYCLES + 1; i++) tick();
    sweepMemory();

    // Full 16-byte load with no load_last, then valid held afterwards
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < DEPTH; i++) sendByte(DW'($urandom), 1'b0);
    load_valid = 1'b1;
    load_data  = 8'hA5;
    for (int i = 0; i < 4; i++) tick();
    load_valid = 1'b0;
    checkVal("count16", 32'(load_count), 32'(DEPTH));
    sweepMemory();

    // Reset while the CPU is running
    asyncReset();
    tick();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reload     = ($urandom_range(0, 39) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = DW'($urandom);
      load_last  = ($urandom_range(0, 5) == 0);
      write      = $urandom_range(0, 1) == 1;
      read       = $urandom_range(0, 1) == 1;
      address    = AW'($urandom);
      memoryIn   = DW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        asyncReset();
      end
      tick();
    end
    idleInputs();
    sweepMemory();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_cpu_boot_mem
`default_nettype wire
